// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC and the IF/ID register, applying hazard-unit stall/flush and
// branch redirects, and replaying a redirect captured while the pipe was stalled.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Stall,
    input  logic          FlushIF,
    input  logic          BranchTaken,
    input  logic [31:0]   BranchTarget,
    input  logic [31:0]   Instruction_IF,
    output logic [31:0]   PC,
    output logic [31:0]   Instruction_ID,
    output logic [31:0]   PCPlus4_ID,
    output logic          Valid_ID,
    output logic          PCWrite,
    output logic          IFIDWrite,
    output logic          RedirectPending,
    output logic [CW-1:0] StallCount,
    output logic [CW-1:0] FlushCount
);

    typedef enum logic [1:0] {StRun, StHold, StHoldPend} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_id_q, instr_id_d;
    logic [31:0]   pcplus4_id_q, pcplus4_id_d;
    logic          valid_id_q, valid_id_d;
    logic [31:0]   pend_target_q, pend_target_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:0]   pc_plus4;
    logic [31:0]   br_target;
    logic          pending;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = {BranchTarget[31:2], 2'b00};
    assign pending   = (state_q == StHoldPend);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_id_d    = instr_id_q;
        pcplus4_id_d  = pcplus4_id_q;
        valid_id_d    = valid_id_q;
        pend_target_d = pend_target_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (Stall) begin
            if (stall_cnt_q != {CW{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
            // First capture wins: a held branch keeps re-asserting BranchTaken.
            if (BranchTaken && !pending) begin
                pend_target_d = br_target;
                state_d       = StHoldPend;
            end else begin
                state_d = pending ? StHoldPend : StHold;
            end
        end else if (pending) begin
            pc_d          = pend_target_q;
            instr_id_d    = 32'h0;
            valid_id_d    = 1'b0;
            pend_target_d = 32'h0;
            if (flush_cnt_q != {CW{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
            state_d       = StRun;
        end else if (BranchTaken || FlushIF) begin
            pc_d       = BranchTaken ? br_target : pc_plus4;
            instr_id_d = 32'h0;
            valid_id_d = 1'b0;
            if (flush_cnt_q != {CW{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
            state_d    = StRun;
        end else begin
            pc_d         = pc_plus4;
            instr_id_d   = Instruction_IF;
            pcplus4_id_d = pc_plus4;
            valid_id_d   = 1'b1;
            state_d      = StRun;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            instr_id_q    <= 32'h0;
            pcplus4_id_q  <= 32'h0;
            valid_id_q    <= 1'b0;
            pend_target_q <= 32'h0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_id_q    <= instr_id_d;
            pcplus4_id_q  <= pcplus4_id_d;
            valid_id_q    <= valid_id_d;
            pend_target_q <= pend_target_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign PC              = pc_q;
    assign Instruction_ID  = instr_id_q;
    assign PCPlus4_ID      = pcplus4_id_q;
    assign Valid_ID        = valid_id_q;
    assign PCWrite         = ~Stall;
    assign IFIDWrite       = ~Stall;
    assign RedirectPending = pending;
    assign StallCount      = stall_cnt_q;
    assign FlushCount      = flush_cnt_q;

endmodule
